me_result_collector: RTL and testbench

Receive-side companion to the modular-exponentiation engine (`me_top`). The engine emits its K-bit result as a stream of 8-bit `me_result` bytes qualified by `me_valid`. This block counts and assembles those bytes into a K-bit result buffer and flags completion. It exposes the buffer to the SoC register interface as 32-bit words. It sits between `me_top` and the RSA APB register file, one instance per engine.

---
 rtl/me_pkg.sv | 26 ++
 rtl/me_rx_wdt.sv | 28 ++
 rtl/me_result_collector.sv | 129 ++++++++++++
 tb/tb_me_result_collector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the modular-exponentiation engine, its APB register file
// and the result collector: collector state encoding plus byte/word geometry of K.
package me_pkg;

  typedef enum logic [1:0] {
    ME_IDLE    = 2'd0,
    ME_COLLECT = 2'd1,
    ME_DONE    = 2'd2
  } me_col_state_t;

  // Default geometry; instances with a different K derive theirs with the helpers.
  localparam int ME_K      = 2048;
  localparam int ME_BYTES  = ME_K / 8;
  localparam int ME_WORDS  = ME_K / 32;
  localparam int ME_CNT_W  = $clog2(ME_BYTES + 1);
  localparam int ME_IDX_W  = $clog2(ME_WORDS);

  function automatic int me_cnt_w(input int k);
    return $clog2(k / 8 + 1);
  endfunction

  function automatic int me_idx_w(input int k);
    return $clog2(k / 32);
  endfunction

endpackage

// File: rtl/me_rx_wdt.sv
// Idle watchdog for the result collector: counts enabled cycles since the last
// clear and flags the cycle on which the TIMEOUT-th idle cycle is reached.
module me_rx_wdt #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Combinational so the collector leaves COLLECT on the edge of the last idle cycle.
  assign expired = en && !clr && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/me_result_collector.sv
// Assembles the me_top result byte stream (LSB first) into a K-bit buffer read as
// 32-bit words. Optional idle timeout is built when ME_COLLECT_TIMEOUT_EN is defined.
module me_result_collector
  import me_pkg::*;
#(
  parameter int K       = ME_K,
  parameter int TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        me_start,
  input  logic                        me_valid,
  input  logic [7:0]                  me_result,
  input  logic                        res_ack,
  input  logic [$clog2(K/32)-1:0]     res_idx,
  output logic [31:0]                 res_word,
  output logic                        res_done,
  output logic                        res_busy,
  output logic                        res_err,
  output logic [$clog2(K/8+1)-1:0]    res_cnt
);

  localparam int NBYTES = K / 8;
  localparam int NWORDS = K / 32;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int IW     = $clog2(NWORDS);

  // Handshake: me_valid is a one-cycle qualifier with no ready; a byte is accepted
  // exactly when me_valid is high in COLLECT and me_start is low the same cycle.

  me_col_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            wr_en;
  logic            expired;
  logic [K-1:0]    buf_q;
  logic [31:0]     word_q, word_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (me_start) begin
      state_d = ME_COLLECT;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ME_IDLE: begin
          if (me_valid) err_d = 1'b1;
        end
        ME_COLLECT: begin
          if (me_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NBYTES - 1)) state_d = ME_DONE;
          end else if (expired) begin
            err_d   = 1'b1;
            state_d = ME_IDLE;
          end
        end
        ME_DONE: begin
          if (me_valid) err_d = 1'b1;
          if (res_ack) state_d = ME_IDLE;
        end
        default: state_d = ME_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ME_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Byte-enable writes; restarts never clear the buffer, only reset does.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (cnt_q == CW'(b)) buf_q[8*b +: 8] <= me_result;
      end
    end
  end

  always_comb begin
    word_sel = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (res_idx == IW'(w)) word_sel = buf_q[32*w +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_sel;
  end

`ifdef ME_COLLECT_TIMEOUT_EN
  me_rx_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (me_start || me_valid || (state_q != ME_COLLECT)),
    .en      (state_q == ME_COLLECT),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expired        = 1'b0;
`endif

  assign res_word = word_q;
  assign res_done = (state_q == ME_DONE);
  assign res_busy = (state_q == ME_COLLECT);
  assign res_err  = err_q;
  assign res_cnt  = cnt_q;

endmodule

// File: tb/tb_me_result_collector.sv
// Directed bench for me_result_collector at K=64 (8 bytes, 2 words), TIMEOUT=16.
module tb_me_result_collector;

  localparam int K       = 64;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(K/32);
  localparam int CW      = $clog2(K/8+1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           me_start = 1'b0;
  logic           me_valid = 1'b0;
  logic [7:0]     me_result = '0;
  logic           res_ack = 1'b0;
  logic [IW-1:0]  res_idx = '0;
  logic [31:0]    res_word;
  logic           res_done;
  logic           res_busy;
  logic           res_err;
  logic [CW-1:0]  res_cnt;

  me_result_collector #(
    .K       (K),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .me_start  (me_start),
    .me_valid  (me_valid),
    .me_result (me_result),
    .res_ack   (res_ack),
    .res_idx   (res_idx),
    .res_word  (res_word),
    .res_done  (res_done),
    .res_busy  (res_busy),
    .res_err   (res_err),
    .res_cnt   (res_cnt)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    me_start = 1'b1;
    tick();
    me_start = 1'b0;
  endtask

  task automatic pulse_ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    me_valid  = 1'b1;
    me_result = b;
    tick();
    me_valid  = 1'b0;
  endtask

  task automatic read_word(input int idx, input string tag);
    res_idx = IW'(idx);
    tick();
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, res_word);
    end else begin
      check(tag, res_word, exp_q.pop_front());
    end
  endtask

  task automatic check_flags(input string tag, input logic busy, input logic done,
                             input logic err, input int cnt);
    check({tag, "_busy"}, 32'(res_busy), 32'(busy));
    check({tag, "_done"}, 32'(res_done), 32'(done));
    check({tag, "_err"},  32'(res_err),  32'(err));
    check({tag, "_cnt"},  32'(res_cnt),  32'(cnt));
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_flags("reset", 1'b0, 1'b0, 1'b0, 0);
    check("reset_word_out", res_word, 32'h0);
    exp_q.push_back(32'h0);
    read_word(1, "reset_w1");

    // byte in IDLE: dropped, sticky error, count stays 0
    send_byte(8'h5A);
    check_flags("idle_valid", 1'b0, 1'b0, 1'b1, 0);
    tick();
    check("idle_err_sticky", 32'(res_err), 32'h1);

    // nominal back-to-back stream; start clears the error
    pulse_start();
    check_flags("nom_start", 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)));
    check_flags("nom_last", 1'b0, 1'b1, 1'b0, 8);
    exp_q.push_back(32'h44332211);
    read_word(0, "nom_w0");
    exp_q.push_back(32'h88776655);
    read_word(1, "nom_w1");

    // ack in DONE returns to IDLE, ack in IDLE does nothing
    pulse_ack();
    check_flags("ack_done", 1'b0, 1'b0, 1'b0, 8);
    pulse_ack();
    check_flags("ack_idle", 1'b0, 1'b0, 1'b0, 8);

    // restart mid-collection; byte with the second start is dropped
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check_flags("rst3", 1'b1, 1'b0, 1'b0, 3);
    exp_q.push_back(32'h44030201);
    read_word(0, "rst3_stale_w0");
    me_valid  = 1'b1;
    me_result = 8'hFF;
    pulse_start();
    me_valid  = 1'b0;
    check_flags("restart", 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    check_flags("restart_done", 1'b0, 1'b1, 1'b0, 8);
    exp_q.push_back(32'hA3A2A1A0);
    read_word(0, "restart_w0");
    exp_q.push_back(32'hA7A6A5A4);
    read_word(1, "restart_w1");
    pulse_ack();

    // gapped stream with random idle cycles between bytes
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      send_byte(8'(8'h11 * (i + 1)));
    end
    check_flags("gap_done", 1'b0, 1'b1, 1'b0, 8);
    exp_q.push_back(32'h44332211);
    read_word(0, "gap_w0");
    exp_q.push_back(32'h88776655);
    read_word(1, "gap_w1");

    // 9th byte in DONE: error, buffer untouched
    send_byte(8'hEE);
    check_flags("ninth", 1'b0, 1'b1, 1'b1, 8);
    exp_q.push_back(32'h44332211);
    read_word(0, "ninth_w0");
    exp_q.push_back(32'h88776655);
    read_word(1, "ninth_w1");

    // start together with ack in DONE: start wins and clears the error
    me_start = 1'b1;
    pulse_ack();
    me_start = 1'b0;
    check_flags("start_ack", 1'b1, 1'b0, 1'b0, 0);

    // reset after 5 bytes clears everything, buffer included
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i));
    check_flags("pre_rst", 1'b1, 1'b0, 1'b0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0, 0);
    check("mid_rst_word_out", res_word, 32'h0);
    exp_q.push_back(32'h0);
    read_word(0, "mid_rst_w0");
    exp_q.push_back(32'h0);
    read_word(1, "mid_rst_w1");

    // idle timeout behaviour
    pulse_start();
    send_byte(8'hC1);
    send_byte(8'hC2);
`ifdef ME_COLLECT_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    check_flags("tmo_before", 1'b1, 1'b0, 1'b0, 2);
    tick();
    check_flags("tmo_expired", 1'b0, 1'b0, 1'b1, 2);
`else
    repeat (100) tick();
    check_flags("no_tmo", 1'b1, 1'b0, 1'b0, 2);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
